// File: rtl/stg_mr_retire_pkg.sv
// Shared definitions for the retire-side macro collapser: address sizing,
// error bit indices, FSM encodings and a saturating length helper.
package stg_mr_retire_pkg;

  // Address sizing shared with the rest of the amber pipeline.
  localparam int HBIT_ADDR = 31;
  localparam int SIZE_ADDR = HBIT_ADDR + 1;

  // Sticky error bit indices.
  localparam int MR_ERR_FIRST_OPEN = 0;  // first micro-op while a sequence is open
  localparam int MR_ERR_ORPHAN     = 1;  // non-first micro-op while idle
  localparam int MR_ERR_PC_CHANGE  = 2;  // PC changed inside a sequence
  localparam int MR_ERR_TOO_LONG   = 3;  // sequence longer than MAX_SEQ
  localparam int MR_ERR_W          = 4;

  // Width of the open-sequence length register.
  localparam int MR_LEN_W = 3;

  typedef enum logic [0:0] {
    MR_S_IDLE = 1'b0,
    MR_S_OPEN = 1'b1
  } mr_state_e;

  // Length increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [MR_LEN_W-1:0] mr_len_inc(input logic [MR_LEN_W-1:0] len);
    if (len == {MR_LEN_W{1'b1}}) begin
      return len;
    end else begin
      return len + 3'd1;
    end
  endfunction

endpackage

// File: rtl/stg_mr_retire_mr_counter.sv
// Free-running W-bit retire counter with an increment enable; wraps at 2^W.
module mr_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count one event per enabled cycle, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {W{1'b0}};
    end else if (en) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/stg_mr_retire.sv
// Retire-side macro collapser: folds each micro-op sequence from the
// translate stage back into a single architectural retirement, tracks the
// atomic (sequence-open) region and flags stream-protocol violations.
module stg_mr_retire
  import stg_mr_retire_pkg::*;
#(
  parameter int MAX_SEQ = 4,
  parameter int CNT_W   = 24
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_valid,
  input  logic [HBIT_ADDR:0]  iw_pc,
  input  logic                iw_first,
  input  logic                iw_last,
  input  logic                iw_flush,
  input  logic                iw_err_clr,
  output logic                ow_retire,
  output logic [HBIT_ADDR:0]  ow_retire_pc,
  output logic                ow_in_seq,
  output logic [CNT_W-1:0]    ow_macro_cnt,
  output logic [CNT_W-1:0]    ow_uop_cnt,
  output logic [MR_ERR_W-1:0] ow_err
);

  localparam logic [MR_LEN_W-1:0] MAX_LEN = MR_LEN_W'(MAX_SEQ);

  mr_state_e              state;
  logic [HBIT_ADDR:0]     r_pc_open;
  logic [MR_LEN_W-1:0]    r_len;

  logic                   accept;
  logic                   cont;
  logic                   retire;
  logic [HBIT_ADDR:0]     retire_pc;
  logic [MR_LEN_W-1:0]    len_inc;
  logic [MR_ERR_W-1:0]    err_new;

  // Decode this cycle's micro-op: acceptance, continuation, retirement and new errors.
  always_comb begin
    accept    = iw_valid & ~iw_flush;
    cont      = accept & (state == MR_S_OPEN) & ~iw_first;
    len_inc   = mr_len_inc(r_len);
    // A last element retires if it is a pass-through or closes an open sequence.
    retire    = accept & iw_last & (iw_first | (state == MR_S_OPEN));
    // A closing element reports the PC latched at first, not its own.
    retire_pc = cont ? r_pc_open : iw_pc;
    err_new   = 4'b0000;
    if (accept) begin
      err_new[MR_ERR_FIRST_OPEN] = iw_first & (state == MR_S_OPEN);
      err_new[MR_ERR_ORPHAN]     = ~iw_first & (state == MR_S_IDLE);
      err_new[MR_ERR_PC_CHANGE]  = cont & (iw_pc != r_pc_open);
      err_new[MR_ERR_TOO_LONG]   = cont & (len_inc > MAX_LEN);
    end else begin
      err_new = 4'b0000;
    end
  end

  // Sequence FSM with registered retire pulse, retire PC, atomic flag and sticky errors.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state        <= MR_S_IDLE;
      r_pc_open    <= {SIZE_ADDR{1'b0}};
      r_len        <= 3'd0;
      ow_retire    <= 1'b0;
      ow_retire_pc <= {SIZE_ADDR{1'b0}};
      ow_in_seq    <= 1'b0;
      ow_err       <= 4'b0000;
    end else begin
      ow_retire <= retire;
      if (retire) begin
        ow_retire_pc <= retire_pc;
      end else begin
        ow_retire_pc <= ow_retire_pc;
      end
      // Clear and a fresh detection in the same cycle: the fresh bit survives.
      ow_err <= (iw_err_clr ? 4'b0000 : ow_err) | err_new;

      if (iw_flush) begin
        state     <= MR_S_IDLE;
        r_len     <= 3'd0;
        ow_in_seq <= 1'b0;
      end else if (iw_valid) begin
        if (iw_first) begin
          // A first always starts fresh; any open sequence is dropped unretired.
          if (iw_last) begin
            state     <= MR_S_IDLE;
            r_len     <= 3'd0;
            ow_in_seq <= 1'b0;
          end else begin
            state     <= MR_S_OPEN;
            r_pc_open <= iw_pc;
            r_len     <= 3'd1;
            ow_in_seq <= 1'b1;
          end
        end else begin
          case (state)
            MR_S_OPEN: begin
              if (iw_last) begin
                state     <= MR_S_IDLE;
                r_len     <= 3'd0;
                ow_in_seq <= 1'b0;
              end else begin
                state     <= MR_S_OPEN;
                r_len     <= len_inc;
                ow_in_seq <= 1'b1;
              end
            end
            MR_S_IDLE: begin
              state     <= MR_S_IDLE;
              ow_in_seq <= 1'b0;
            end
            default: begin
              state     <= MR_S_IDLE;
              r_len     <= 3'd0;
              ow_in_seq <= 1'b0;
            end
          endcase
        end
      end else begin
        state     <= state;
        ow_in_seq <= ow_in_seq;
      end
    end
  end

  mr_counter #(.W(CNT_W)) u_macro_cnt (
    .clk (iw_clk),
    .rst (iw_rst),
    .en  (retire),
    .cnt (ow_macro_cnt)
  );

  mr_counter #(.W(CNT_W)) u_uop_cnt (
    .clk (iw_clk),
    .rst (iw_rst),
    .en  (accept),
    .cnt (ow_uop_cnt)
  );

endmodule

// File: tb/tb_stg_mr_retire.sv
// Scoreboard bench for stg_mr_retire: a queue-based reference model predicts
// retirements, counters, the atomic flag and sticky errors; a monitor checks
// the DUT against it at every falling clock edge.
module tb_stg_mr_retire;
  import stg_mr_retire_pkg::*;

  localparam int MAX_SEQ = 4;
  localparam int CNT_W   = 4;

  logic               iw_clk = 1'b0;
  logic               iw_rst = 1'b1;
  logic               iw_valid = 1'b0;
  logic [HBIT_ADDR:0] iw_pc = '0;
  logic               iw_first = 1'b0;
  logic               iw_last = 1'b0;
  logic               iw_flush = 1'b0;
  logic               iw_err_clr = 1'b0;
  logic               ow_retire;
  logic [HBIT_ADDR:0] ow_retire_pc;
  logic               ow_in_seq;
  logic [CNT_W-1:0]   ow_macro_cnt;
  logic [CNT_W-1:0]   ow_uop_cnt;
  logic [3:0]         ow_err;

  stg_mr_retire #(.MAX_SEQ(MAX_SEQ), .CNT_W(CNT_W)) dut (
    .iw_clk       (iw_clk),
    .iw_rst       (iw_rst),
    .iw_valid     (iw_valid),
    .iw_pc        (iw_pc),
    .iw_first     (iw_first),
    .iw_last      (iw_last),
    .iw_flush     (iw_flush),
    .iw_err_clr   (iw_err_clr),
    .ow_retire    (ow_retire),
    .ow_retire_pc (ow_retire_pc),
    .ow_in_seq    (ow_in_seq),
    .ow_macro_cnt (ow_macro_cnt),
    .ow_uop_cnt   (ow_uop_cnt),
    .ow_err       (ow_err)
  );

  always #5 iw_clk = ~iw_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model: the open sequence is the list of PCs seen since its first.
  typedef struct {
    logic [HBIT_ADDR:0] pc;
    logic [CNT_W-1:0]   macro;
  } exp_t;

  logic [HBIT_ADDR:0] m_seq[$];
  exp_t               exp_q[$];
  logic [CNT_W-1:0]   m_macro = '0;
  logic [CNT_W-1:0]   m_uop = '0;
  logic [3:0]         m_err = 4'b0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seq.delete();
    exp_q.delete();
    m_macro = '0;
    m_uop   = '0;
    m_err   = 4'b0000;
  endtask

  task automatic model_retire(input logic [HBIT_ADDR:0] pc);
    exp_t e;
    m_macro  = m_macro + 1'b1;
    e.pc     = pc;
    e.macro  = m_macro;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit v, input logic [HBIT_ADDR:0] pc, input bit f,
                            input bit l, input bit fl, input bit clr);
    logic [3:0] new_err;
    new_err = 4'b0000;
    if (fl) begin
      m_seq.delete();
    end else if (v) begin
      m_uop = m_uop + 1'b1;
      if (f) begin
        if (m_seq.size() != 0) new_err[0] = 1'b1;
        m_seq.delete();
        if (l) model_retire(pc);
        else   m_seq.push_back(pc);
      end else if (m_seq.size() == 0) begin
        new_err[1] = 1'b1;
      end else begin
        if (pc != m_seq[0]) new_err[2] = 1'b1;
        m_seq.push_back(pc);
        if (m_seq.size() > MAX_SEQ) new_err[3] = 1'b1;
        if (l) begin
          model_retire(m_seq[0]);
          m_seq.delete();
        end
      end
    end
    m_err = (clr ? 4'b0000 : m_err) | new_err;
  endtask

  // Drive one cycle of stimulus, then advance the model past the active edge.
  task automatic step(input bit v, input logic [HBIT_ADDR:0] pc, input bit f,
                      input bit l, input bit fl, input bit clr);
    @(negedge iw_clk);
    iw_valid = v; iw_pc = pc; iw_first = f; iw_last = l; iw_flush = fl; iw_err_clr = clr;
    @(posedge iw_clk);
    #1;
    model_step(v, pc, f, l, fl, clr);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge iw_clk);
    #2;
    iw_rst = 1'b1;
    model_reset();
    @(negedge iw_clk);
    #1;
    iw_rst = 1'b0;
  endtask

  // Monitor: compare every observable output against the model each falling edge.
  always @(negedge iw_clk) begin
    exp_t e;
    if (mon_en) begin
      chk("in_seq", ow_in_seq, m_seq.size() != 0);
      chk("uop_cnt", ow_uop_cnt, m_uop);
      chk("macro_cnt", ow_macro_cnt, m_macro);
      chk("err", ow_err, m_err);
      chk("retire", ow_retire, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (ow_retire) chk("retire_pc", ow_retire_pc, e.pc);
      end
    end
  end

  initial begin
    logic [HBIT_ADDR:0] cur_pc;
    bit v, f, l, fl, clr;
    logic [HBIT_ADDR:0] pc;

    // Reset values while reset is held.
    #2;
    chk("rst_retire", ow_retire, 1'b0);
    chk("rst_retire_pc", ow_retire_pc, 32'h0);
    chk("rst_in_seq", ow_in_seq, 1'b0);
    chk("rst_macro", ow_macro_cnt, 4'h0);
    chk("rst_uop", ow_uop_cnt, 4'h0);
    chk("rst_err", ow_err, 4'h0);
    #10;
    iw_rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Back-to-back single-op instructions.
    step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("single_macro", ow_macro_cnt, 4'd3);
    chk("single_uop", ow_uop_cnt, 4'd3);

    // Four-op sequence with a two-cycle bubble after op 1.
    step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("seq4_macro", ow_macro_cnt, 4'd4);
    chk("seq4_uop", ow_uop_cnt, 4'd7);
    chk("seq4_err", ow_err, 4'b0000);

    // Flush mid-sequence with a valid micro-op in the flush cycle.
    step(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_in_seq", ow_in_seq, 1'b0);
    step(1'b1, 32'h90, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("flush_uop", ow_uop_cnt, 4'd10);
    chk("flush_macro", ow_macro_cnt, 4'd5);

    // Protocol errors.
    step(1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("orphan_err", ow_err, 4'b0010);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("first_open_err", ow_err, 4'b0001);
    step(1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h31, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("pc_change_err", ow_err, 4'b0101);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Over-long sequence, then error clear.
    step(1'b1, 32'h70, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h70, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("overflow_err", ow_err, 4'b1000);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_err", ow_err, 4'b0000);

    // Counter wrap: 17 single-op instructions from a fresh reset.
    pulse_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 32'h100 + i, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("wrap_macro", ow_macro_cnt, 4'd1);
    chk("wrap_uop", ow_uop_cnt, 4'd1);

    // Randomized stream.
    cur_pc = 32'h200;
    for (int i = 0; i < 800; i++) begin
      fl  = ($urandom % 20) == 0;
      clr = ($urandom % 16) == 0;
      v   = ($urandom % 5) != 0;
      f   = ($urandom % 3) == 0;
      l   = ($urandom % 3) == 0;
      if (f) cur_pc = $urandom;
      pc  = (($urandom % 10) == 0) ? $urandom : cur_pc;
      step(v, pc, f, l, fl, clr);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset asserted while a sequence is open clears outputs immediately.
    step(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("pre_rst_in_seq", ow_in_seq, 1'b1);
    @(negedge iw_clk);
    #2;
    iw_rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_retire", ow_retire, 1'b0);
    chk("midrst_retire_pc", ow_retire_pc, 32'h0);
    chk("midrst_in_seq", ow_in_seq, 1'b0);
    chk("midrst_macro", ow_macro_cnt, 4'h0);
    chk("midrst_uop", ow_uop_cnt, 4'h0);
    chk("midrst_err", ow_err, 4'h0);
    @(negedge iw_clk);
    #1;
    iw_rst = 1'b0;
    idle();
    idle();
    chk("no_pending_retire", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stg_mr_retire.md
# stg_mr_retire

Retire-side macro collapser for the amber pipeline. It consumes the micro-op stream from the translate stage after writeback and reassembles each micro-op sequence into one architectural retirement. It emits one retire pulse with the originating ISA PC per macro instruction, keeps macro and micro-op retire counters, and raises a sequence-open flag so the interrupt/trap logic never breaks into a half-executed expansion. It also flags stream-protocol violations.

## Interface
- MAX_SEQ, 4: longest legal micro-op sequence per macro instruction.
- CNT_W, 24: width of each retire counter.
- iw_clk  in  1  clock.
- iw_rst  in  1  reset: asynchronous, active-high.
- iw_valid  in  1  a micro-op retires this cycle.
- iw_pc  in  `HBIT_ADDR+1  ISA PC carried with the micro-op; held constant across a sequence.
- iw_first  in  1  micro-op is element 0 of its macro instruction.
- iw_last  in  1  micro-op is the final element. first=last=1 marks a pass-through instruction.
- iw_flush  in  1  pipeline flush: abort any open sequence.
- iw_err_clr  in  1  clears sticky error bits.
- ow_retire  out  1  one-cycle pulse, one macro instruction completed.
- ow_retire_pc  out  `HBIT_ADDR+1  PC of the completed macro instruction.
- ow_in_seq  out  1  a sequence is open (atomic region; interrupts blocked).
- ow_macro_cnt  out  CNT_W  completed macro instructions.
- ow_uop_cnt  out  CNT_W  accepted micro-ops.
- ow_err  out  4  sticky: [0] first while open, [1] non-first while idle, [2] PC change inside sequence, [3] length > MAX_SEQ.

## Operation
- FSM states:
  - IDLE, the reset state.
  - OPEN, between the first and last micro-op of a multi-op sequence.
- Registers: r_pc_open (PC latched at first), r_len (3 bits, micro-ops seen in the open sequence).
- An accepted micro-op is iw_valid=1 with iw_flush=0. Every accepted micro-op increments ow_uop_cnt. The counter wraps modulo 2^CNT_W.
- IDLE, first=1, last=1: retire with iw_pc; stay IDLE.
- IDLE, first=1, last=0: latch iw_pc into r_pc_open, set r_len=1, go to OPEN.
- IDLE, first=0: set err[1]; no retire; stay IDLE.
- OPEN, first=0:
  - Increment r_len.
  - If iw_pc != r_pc_open, set err[2].
  - If the new length exceeds MAX_SEQ, set err[3].
  - last=1: retire with r_pc_open (not iw_pc), go to IDLE.
  - last=0: stay OPEN.
- OPEN, first=1: set err[0] and discard the open sequence without retiring it. Then process the micro-op exactly as in IDLE.
- A retire increments ow_macro_cnt by 1, wrapping modulo 2^CNT_W.
- iw_flush=1 forces IDLE and clears r_len, regardless of state or iw_valid. The micro-op in the same cycle is ignored: no count, no retire, no error.
- iw_err_clr clears ow_err. If a new error is detected in the same cycle, that bit is set (set wins).
- r_len saturates at 7. err[3] stays set once raised.

## Timing
- All outputs are registered.
- Latency: ow_retire and ow_retire_pc assert the cycle after the last micro-op is accepted. Counters update on that same edge.
- ow_in_seq:
  - rises the cycle after an accepted first-without-last;
  - falls the cycle after the accepted last or the flush;
  - stays high through iw_valid=0 bubbles.
- ow_retire is high for exactly one cycle per retirement. Back-to-back single-op instructions give consecutive pulses.
- A first micro-op accepted in the cycle after a last is legal, with no gap required.
- Reset values:
  - ow_retire=0, ow_retire_pc=0, ow_in_seq=0, ow_macro_cnt=0, ow_uop_cnt=0, ow_err=0;
  - state IDLE, r_len=0, r_pc_open=0.
- Asserting reset mid-sequence drops the sequence with no retire.

## Structure
- Shared header (next to sizes.vh): MR_ERR_* bit indices, FSM state encodings (MR_S_IDLE, MR_S_OPEN).
- Reuse `HBIT_ADDR and `SIZE_ADDR from sizes.vh.
- One natural sub-module: mr_counter, a CNT_W-wide incrementer with enable. It is instantiated twice, once for macro and once for micro-op counts.

## Test plan
- Single-op instructions: 3 consecutive accepted micro-ops with first=last=1 at PCs 0x10, 0x11, 0x12 -> three consecutive retire pulses with PCs 0x10/0x11/0x12; macro_cnt=3, uop_cnt=3, in_seq never high.
- Four-op call sequence: 4 micro-ops at PC 0x40 (first on op 0, last on op 3), with a 2-cycle valid=0 bubble after op 1 -> in_seq high from the cycle after op 0 until the cycle after op 3; one retire with PC 0x40; uop_cnt=4, macro_cnt=1, err=0.
- Flush mid-sequence: flush after op 1 of a 3-op sequence at 0x80, with valid=1 in the flush cycle -> no retire; in_seq low the next cycle; uop_cnt=2; then a single-op instruction at 0x90 retires normally.
- Protocol errors:
  - orphan last while IDLE -> err=0b0010, no retire;
  - new first at 0xA0 while a sequence at 0x60 is open -> err[0] set, 0x60 never retires, 0xA0 retires;
  - mid-sequence PC change -> err[2] set.
- Overflow and error clear: a 5-op sequence -> err[3] set, single retire at the latched PC; then pulse err_clr -> err=0 next cycle.
- Counter wrap and reset: with CNT_W=4, 17 single-op instructions -> macro_cnt=1. Assert reset while in_seq=1 -> all outputs 0 immediately.
